// File: rtl/clause_processor_scheduler.sv
// rtl/clause_processor_scheduler.sv - round-robin, credit-metered literal issue into a shared clause processor
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid_i         per-lane literal pending
//   req_literal_i       per-lane literal, lane i at slice i
//   req_ready_o         one-hot accept strobe (combinational)
//   literal_o           registered literal into the clause processor
//   literal_valid_o     literal_o valid this cycle
//   grant_id_o          lane that owns literal_o
//   result_ack_i        one pipeline result consumed; returns a credit
//   result_id_o         lane owning the oldest outstanding result
//   result_id_valid_o   at least one result outstanding
//   flush_i             single-cycle flush request
//   credits_o           free credits
//   busy_o              not idle or results outstanding
module clause_processor_scheduler #(
  parameter int NUM_REQ               = 4,
  parameter int LITERAL_ADDRESS_WIDTH = 11,
  parameter int CREDITS               = 8,
  parameter int ID_BITS               = $clog2(NUM_REQ),
  parameter int CREDIT_BITS           = $clog2(CREDITS) + 1
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [NUM_REQ-1:0]                             req_valid_i,
  input  logic [NUM_REQ*(LITERAL_ADDRESS_WIDTH+1)-1:0]   req_literal_i,
  output logic [NUM_REQ-1:0]                             req_ready_o,
  output logic [LITERAL_ADDRESS_WIDTH:0]                 literal_o,
  output logic                                           literal_valid_o,
  output logic [ID_BITS-1:0]                             grant_id_o,
  input  logic                                           result_ack_i,
  output logic [ID_BITS-1:0]                             result_id_o,
  output logic                                           result_id_valid_o,
  input  logic                                           flush_i,
  output logic [CREDIT_BITS-1:0]                         credits_o,
  output logic                                           busy_o
);

  localparam int LW       = LITERAL_ADDRESS_WIDTH + 1;
  localparam int PTR_BITS = $clog2(CREDITS);
  localparam logic [CREDIT_BITS-1:0] CREDITS_FULL = CREDIT_BITS'(CREDITS);
  localparam logic [ID_BITS-1:0]     LAST_INIT    = ID_BITS'(NUM_REQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [CREDIT_BITS-1:0]  credits_q, credits_d;
  logic [ID_BITS-1:0]      last_grant_q, last_grant_d;
  logic [LW-1:0]           literal_q, literal_d;
  logic                    literal_valid_q, literal_valid_d;
  logic [ID_BITS-1:0]      grant_id_q, grant_id_d;
  logic [PTR_BITS-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ID_BITS-1:0]      tag_mem_q [CREDITS];
  logic [ID_BITS-1:0]      tag_mem_d [CREDITS];

  logic [LW-1:0]           lane_lit [NUM_REQ];
  logic                    arb_found;
  logic [ID_BITS-1:0]      arb_grant;
  logic [ID_BITS-1:0]      arb_cand;
  logic                    fifo_empty;
  logic                    issue;
  logic                    ack_eff;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane_lit
    assign lane_lit[i] = req_literal_i[i*LW +: LW];
  end

  // Rotating priority: first valid lane at or after last_grant+1.
  always_comb begin
    arb_found = 1'b0;
    arb_grant = '0;
    arb_cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      arb_cand = ID_BITS'((int'(last_grant_q) + 1 + off) % NUM_REQ);
      if (!arb_found && req_valid_i[arb_cand]) begin
        arb_found = 1'b1;
        arb_grant = arb_cand;
      end
    end
  end

  // Outstanding tag count is CREDITS - credits, so the FIFO needs no counter.
  assign fifo_empty = (credits_q == CREDITS_FULL);
  assign issue      = (state_q != ST_FLUSH) && !flush_i && (credits_q != '0) && arb_found;
  // An ack with nothing outstanding is dropped so credits never exceed CREDITS.
  assign ack_eff    = result_ack_i && !fifo_empty;

  always_comb begin
    state_d         = state_q;
    credits_d       = credits_q;
    last_grant_d    = last_grant_q;
    literal_d       = literal_q;
    literal_valid_d = 1'b0;
    grant_id_d      = grant_id_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    tag_mem_d       = tag_mem_q;
    req_ready_o     = '0;

    if (issue) begin
      req_ready_o[arb_grant] = 1'b1;
      literal_d              = lane_lit[arb_grant];
      grant_id_d             = arb_grant;
      literal_valid_d        = 1'b1;
      last_grant_d           = arb_grant;
      tag_mem_d[wr_ptr_q]    = arb_grant;
      wr_ptr_d               = wr_ptr_q + 1'b1;
    end

    if (ack_eff) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (issue && !ack_eff) begin
      credits_d = credits_q - 1'b1;
    end else if (!issue && ack_eff) begin
      credits_d = credits_q + 1'b1;
    end

    if (flush_i) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:  if (|req_valid_i) state_d = ST_RUN;
        ST_RUN:   if (!(|req_valid_i) && (credits_q == CREDITS_FULL)) state_d = ST_IDLE;
        // Exit on the post-ack credit value so the final ack ends the flush.
        ST_FLUSH: if (credits_d == CREDITS_FULL) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      credits_q       <= CREDITS_FULL;
      last_grant_q    <= LAST_INIT;
      literal_q       <= '0;
      literal_valid_q <= 1'b0;
      grant_id_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      tag_mem_q       <= '{default: '0};
    end else begin
      state_q         <= state_d;
      credits_q       <= credits_d;
      last_grant_q    <= last_grant_d;
      literal_q       <= literal_d;
      literal_valid_q <= literal_valid_d;
      grant_id_q      <= grant_id_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      tag_mem_q       <= tag_mem_d;
    end
  end

  assign literal_o         = literal_q;
  assign literal_valid_o   = literal_valid_q;
  assign grant_id_o        = grant_id_q;
  assign result_id_o       = tag_mem_q[rd_ptr_q];
  assign result_id_valid_o = !fifo_empty;
  assign credits_o         = credits_q;
  assign busy_o            = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_clause_processor_scheduler.sv
// tb/tb_clause_processor_scheduler.sv - self-checking bench for clause_processor_scheduler
module tb_clause_processor_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [47:0] lit_bus;
  logic [3:0]  req_ready_o;
  logic [11:0] literal_o;
  logic        literal_valid_o;
  logic [1:0]  grant_id_o;
  logic        result_ack;
  logic [1:0]  result_id_o;
  logic        result_id_valid_o;
  logic        flush;
  logic [3:0]  credits_o;
  logic        busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: 0 IDLE, 1 RUN, 2 FLUSH
  int          m_state;
  int          m_credits;
  int          m_last;
  int          m_tags[$];
  logic [11:0] sb_lit[$];
  int          sb_gid[$];
  logic        last_issue;

  clause_processor_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid_i       (req_valid),
    .req_literal_i     (lit_bus),
    .req_ready_o       (req_ready_o),
    .literal_o         (literal_o),
    .literal_valid_o   (literal_valid_o),
    .grant_id_o        (grant_id_o),
    .result_ack_i      (result_ack),
    .result_id_o       (result_id_o),
    .result_id_valid_o (result_id_valid_o),
    .flush_i           (flush),
    .credits_o         (credits_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; result_ack = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_state = 0; m_credits = 8; m_last = 3;
    m_tags.delete(); sb_lit.delete(); sb_gid.delete();
    #1;
    chk("rst_literal", literal_o, 0);
    chk("rst_lit_valid", literal_valid_o, 0);
    chk("rst_grant_id", grant_id_o, 0);
    chk("rst_result_id", result_id_o, 0);
    chk("rst_rid_valid", result_id_valid_o, 0);
    chk("rst_credits", credits_o, 8);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", req_ready_o, 0);
  endtask

  // One clock: drive, check combinational/registered state against the model,
  // advance the model, then pop the scoreboard against the registered literal.
  task automatic step(input logic [3:0] v, input logic ack, input logic fl);
    int g;
    int c;
    int old_credits;
    logic issue;
    logic ack_eff;
    logic found;
    logic [3:0] exp_rdy;
    req_valid = v; result_ack = ack; flush = fl;
    #1;
    chk("credits", credits_o, m_credits);
    chk("rid_valid", result_id_valid_o, m_tags.size() != 0);
    if (m_tags.size() != 0) chk("result_id", result_id_o, m_tags[0]);
    chk("busy", busy_o, (m_state != 0) || (m_credits != 8));
    issue = (m_state != 2) && !fl && (m_credits > 0) && (v != 4'b0);
    g = 0; found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      c = (m_last + k) % 4;
      if (!found && v[c]) begin g = c; found = 1'b1; end
    end
    exp_rdy = issue ? 4'(1 << g) : 4'b0;
    chk("req_ready", req_ready_o, exp_rdy);
    ack_eff = ack && (m_tags.size() != 0);
    if (ack_eff) void'(m_tags.pop_front());
    if (issue) begin
      sb_lit.push_back(lit_bus[g*12 +: 12]);
      sb_gid.push_back(g);
      m_tags.push_back(g);
      m_last = g;
    end
    old_credits = m_credits;
    m_credits = m_credits - int'(issue) + int'(ack_eff);
    if (fl) m_state = 2;
    else if (m_state == 0 && v != 4'b0) m_state = 1;
    else if (m_state == 1 && v == 4'b0 && old_credits == 8) m_state = 0;
    else if (m_state == 2 && m_credits == 8) m_state = 0;
    last_issue = issue;
    @(posedge clk); #1;
    chk("lit_valid", literal_valid_o, issue);
    if (issue) begin
      chk("literal", literal_o, sb_lit.pop_front());
      chk("grant_id", grant_id_o, sb_gid.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    lit_bus = {12'h3C3, 12'h805, 12'h1A1, 12'hF00};
    reset = 1'b1; req_valid = '0; result_ack = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    // Single lane 2 request
    do_reset();
    step(4'b0100, 1'b0, 1'b0);
    chk("lane2_literal", literal_o, 12'h805);
    chk("lane2_grant", grant_id_o, 2);
    chk("lane2_credits", credits_o, 7);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("lane2_idle_busy", busy_o, 0);

    // All lanes, ack every cycle from cycle 3
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 1'b0);
    chk("rr_steady_credits", credits_o, 5);
    chk("rr_last_grant", grant_id_o, 2);

    // No acks: credits exhaust after 8 grants
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 1'b0);
    chk("exhaust_credits", credits_o, 0);
    step(4'b1111, 1'b0, 1'b0);
    chk("exhaust_no_issue", last_issue, 0);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    chk("exhaust_one_more", last_issue, 1);
    chk("exhaust_credits2", credits_o, 0);
    step(4'b1111, 1'b0, 1'b0);
    chk("exhaust_stop_again", last_issue, 0);

    // Flush with three in flight
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b1);
    chk("flush_busy", busy_o, 1);
    step(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0);
    chk("flush_credits_back", credits_o, 8);
    chk("flush_idle_busy", busy_o, 0);
    step(4'b1111, 1'b0, 1'b0);
    chk("flush_resume_grant", grant_id_o, 3);

    // Ack with nothing outstanding
    do_reset();
    step(4'b0000, 1'b1, 1'b0);
    chk("spurious_ack_credits", credits_o, 8);
    chk("spurious_ack_rid", result_id_valid_o, 0);

    // Reset with five in flight
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 1'b0);
    do_reset();
    step(4'b1111, 1'b0, 1'b0);
    chk("post_reset_grant", grant_id_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clause_processor_scheduler.md
# clause_processor_scheduler

Round-robin scheduler that shares one clause processor pipeline between NUM_REQ clause-selector lanes. It grants one literal per cycle into the pipeline. It meters issue with credits sized to the downstream FIFO tree capacity. It records the granting lane of every issued literal, so results leaving the pipeline can be routed back to their lane in order. It also sequences a flush that stops issue and drains the pipeline.

## Interface
- NUM_REQ, 4, number of requesting lanes (≥2)
- LITERAL_ADDRESS_WIDTH, 11, literal index width; literal bus is LITERAL_ADDRESS_WIDTH+1 bits (MSB = polarity)
- CREDITS, 8, maximum literals in flight (pipeline plus FIFO tree); power of two, ≥2
- ID_BITS, $clog2(NUM_REQ), lane-id width
- CREDIT_BITS, $clog2(CREDITS)+1, credit counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req_valid_i  in  NUM_REQ  lane i has a literal pending
- req_literal_i  in  NUM_REQ*(LITERAL_ADDRESS_WIDTH+1)  lane i literal at slice i
- req_ready_o  out  NUM_REQ  one-hot (or zero) accept strobe, combinational
- literal_o  out  LITERAL_ADDRESS_WIDTH+1  literal to clause processor, registered
- literal_valid_o  out  1  literal_o valid this cycle, registered
- grant_id_o  out  ID_BITS  lane of literal_o, registered
- result_ack_i  in  1  clause processor output consumed; returns one credit
- result_id_o  out  ID_BITS  lane owning the oldest outstanding result
- result_id_valid_o  out  1  at least one result outstanding
- flush_i  in  1  single-cycle flush request
- credits_o  out  CREDIT_BITS  free credits
- busy_o  out  1  state ≠ IDLE or credits_o ≠ CREDITS

## Operation
- States: IDLE, RUN, FLUSH. Reset → IDLE.
- IDLE → RUN on any req_valid_i; RUN → IDLE when no req_valid_i and credits_o == CREDITS. On flush_i, any state → FLUSH; flush_i has priority over both transitions.
- FLUSH: no issue (req_ready_o = 0). Leave to IDLE in the first cycle credits_o == CREDITS, evaluated including that cycle's ack. Outstanding results are still acked normally.
- Issue condition: state ∈ {IDLE, RUN}, flush_i low, credits_o > 0, and some req_valid_i set.
- Arbitration: round-robin. Search starts at lane (last_grant+1) mod NUM_REQ. last_grant resets to NUM_REQ-1, so lane 0 has first priority. last_grant updates only on issue.
- On issue to lane g:
  - req_ready_o[g]=1.
  - Next cycle: literal_o ← slice g, grant_id_o ← g, literal_valid_o=1.
  - Push g into the tag FIFO (depth CREDITS).
  - credits_o decrements.
- Without issue, literal_valid_o=0; literal_o and grant_id_o hold their values.
- result_ack_i:
  - Pops the tag FIFO and increments credits_o.
  - Issue and ack in the same cycle: net credits unchanged; the FIFO pushes and pops together.
  - Ack while result_id_valid_o=0 is ignored (no underflow, credits saturate at CREDITS).
- result_id_o = tag FIFO head; result_id_valid_o = FIFO non-empty. Tag count always equals CREDITS − credits_o.
- Tag FIFO pointers are log2(CREDITS) bits and wrap naturally; it cannot overflow because issue requires a credit.
- Reset mid-operation:
  - All credits returned, FIFO emptied, state IDLE, last_grant=NUM_REQ-1.
  - literal_valid_o=0, literal_o=0, grant_id_o=0.
  - Results still in the pipeline are the owner's responsibility (reset whole processor).

## Timing
- Reset values: literal_o=0, literal_valid_o=0, grant_id_o=0, result_id_o=0, result_id_valid_o=0, credits_o=CREDITS, busy_o=0, req_ready_o=0.
- Accept-to-literal_valid_o latency: 1 cycle. Throughput: one literal/cycle while credits remain.
- credits_o reflects issue/ack from the previous cycle. req_ready_o is combinational from req_valid_i, state, credits_o, flush_i.
- Lane must hold req_literal_i stable while req_valid_i is high until its req_ready_o strobe.
- result_id_o changes the cycle after each ack that leaves the FIFO non-empty.

## Test plan
- Reset, lane 2 only valid, literal 12'h805 → cycle 0: req_ready_o=4'b0100; cycle 1: literal_o=12'h805, grant_id_o=2, literal_valid_o=1; credits_o=7.
- All 4 lanes valid continuously, ack every cycle from cycle 3 → grants 0,1,2,3,0,…; credits_o settles at constant 5 (issue+ack net zero); result_id_o follows 0,1,2,3 in order.
- 4 lanes valid, no acks → exactly 8 grants, then req_ready_o=0 with credits_o=0. One ack → one further grant next cycle.
- 3 issued, flush_i while lanes valid → no ready in FLUSH; 3 acks → IDLE the cycle credits_o returns to 8; busy_o=0 one cycle later.
- result_ack_i with empty tag FIFO → credits_o stays 8, result_id_valid_o stays 0.
- reset asserted with 5 in flight → next cycle credits_o=8, result_id_valid_o=0, lane 0 wins the next grant.
